// File: rtl/sysbus_pkg.sv
// Shared system-bus response types, constants and select-decode helper.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } resp_state_e;

  localparam int unsigned SEL_NONE        = 0;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // Slave indices are 1-based; 0 and anything above n decode to no slave.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
    return (sel != SEL_NONE) && (sel <= n);
  endfunction

endpackage

// File: rtl/resp_timeout_cnt.sv
// Saturating WAIT-cycle counter; expired is high during the WAIT cycle whose
// closing edge completes LIMIT cycles without a slave response.
module resp_timeout_cnt
  import sysbus_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Count saturates at LIMIT; expiry flag is pre-computed so it is a flop output.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d >= CNT_W'(LIMIT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/slave_resp_mux.sv
// Response-path mux: latches the slave index at req, waits for that slave's
// ready and returns a registered one-cycle ready/rdata/err to the master.
// Optional WAIT timeout error enabled by SLAVE_RESP_MUX_TIMEOUT_EN.
module slave_resp_mux
  import sysbus_pkg::*;
#(
  parameter int unsigned N_SLAVES       = 3,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic [SEL_W-1:0]             select,
  input  logic [N_SLAVES-1:0]          s_ready,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  output logic                         ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         err,
  output logic                         busy
);

  if ((2 ** SEL_W) <= N_SLAVES || N_SLAVES < 1 || N_SLAVES > 15 || TIMEOUT_CYCLES < 1)
  begin : g_bad_params
    $error("slave_resp_mux: illegal parameter combination");
  end

  resp_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              sel_ready_c;
  logic [DATA_W-1:0] sel_rdata_c;

`ifdef SLAVE_RESP_MUX_TIMEOUT_EN
  logic cnt_clr_c;
  logic cnt_inc_c;
  logic timeout_c;

  resp_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr_c),
    .inc     (cnt_inc_c),
    .expired (timeout_c)
  );
`endif

  // Pick the latched slave's ready bit and data slice; SEL_NONE matches nothing.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel_q == SEL_W'(i + 1)) begin
        sel_ready_c = s_ready[i];
        sel_rdata_c = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // An invalid select is latched as SEL_NONE and turned into the error
  // response from WAIT, so decode errors share the registered response path.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
`ifdef SLAVE_RESP_MUX_TIMEOUT_EN
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
`ifdef SLAVE_RESP_MUX_TIMEOUT_EN
        cnt_clr_c = 1'b1;
`endif
        if (req) begin
          state_d = WAIT;
          busy_d  = 1'b1;
          sel_d   = sel_valid(32'(select), N_SLAVES) ? select : SEL_W'(SEL_NONE);
        end
      end
      WAIT: begin
        if (sel_q == SEL_W'(SEL_NONE)) begin
          state_d = ERR;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (sel_ready_c) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = sel_rdata_c;
        end else begin
`ifdef SLAVE_RESP_MUX_TIMEOUT_EN
          cnt_inc_c = 1'b1;
          if (timeout_c) begin
            state_d = ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      ERR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_W'(SEL_NONE);
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_slave_resp_mux.sv
// Scoreboard bench for slave_resp_mux: the driver predicts each response
// (cycle, err, data) from the transaction it issues; a negedge monitor checks.
module tb_slave_resp_mux;

  localparam int NS = 5;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int TO = 16;
`ifdef SLAVE_RESP_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [SW-1:0]    select = '0;
  logic [NS-1:0]    s_ready = '0;
  logic [NS*DW-1:0] s_rdata = '0;
  logic             ready;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             busy;

  slave_resp_mux #(
    .N_SLAVES       (NS),
    .DATA_W         (DW),
    .SEL_W          (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .select  (select),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .ready   (ready),
    .rdata   (rdata),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic          e;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          expq[$];
  int            n_checks = 0;
  int            n_err = 0;
  bit            checking = 1'b0;
  bit            exp_busy = 1'b0;
  logic [DW-1:0] model_rdata = '0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every response must match the head of the expectation queue.
  always @(negedge clk) begin
    if (checking) begin
      while (expq.size() > 0 && expq[0].at < cyc) begin
        chk("missing_ready", 0, 1);
        void'(expq.pop_front());
      end
      if (ready) begin
        if (expq.size() == 0) begin
          chk("spurious_ready", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("resp_cycle", cyc, e.at);
          chk("resp_err", int'(err), int'(e.e));
          model_rdata = e.e ? '0 : e.d;
        end
      end else begin
        chk("err_idle", int'(err), 0);
      end
      chk("rdata", int'(rdata), int'(model_rdata));
      chk("busy", int'(busy), int'(exp_busy));
    end
  end

  task automatic set_slice(input int idx, input logic [DW-1:0] d);
    s_rdata[idx*DW +: DW] = d;
  endtask

  // Random activity on everything except the given 1-based slave's ready.
  task automatic noise_excl(input int sel);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    s_rdata = r[NS*DW-1:0];
    s_ready = NS'($urandom());
    for (int i = 0; i < NS; i++) if (i == sel - 1) s_ready[i] = 1'b0;
    select = SW'($urandom());
    req = 1'($urandom());
  endtask

  task automatic drive_wait(input int sel, input bit hold3);
    if (hold3) begin
      noise_excl(sel);
      select  = SW'(3);
      s_ready = NS'(5'b00100);
      set_slice(2, 8'h3C);
    end else begin
      noise_excl(sel);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      noise_excl(0);
      req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // One transaction: select sel, selected slave answers on the k-th WAIT edge.
  task automatic issue(input int sel, input int k, input logic [DW-1:0] d, input bit hold3);
    int   p;
    int   eff;
    bit   valid;
    bit   tmo;
    exp_t e;
    valid = (sel >= 1) && (sel <= NS);
    req = 1'b1;
    select = SW'(sel);
    p = cyc;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    if (!valid) begin
      e = '{p + 2, 1'b1, '0};
      expq.push_back(e);
      noise_excl(0);
      @(posedge clk); #1;
      noise_excl(0);
      @(posedge clk); #1;
      req = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    tmo = TO_EN && (k > TO);
    eff = tmo ? TO : k;
    for (int j = 1; j < eff; j++) begin
      drive_wait(sel, hold3);
      @(posedge clk); #1;
    end
    drive_wait(sel, hold3);
    if (tmo) begin
      e = '{p + 1 + TO, 1'b1, '0};
    end else begin
      s_ready[sel-1] = 1'b1;
      set_slice(sel - 1, d);
      e = '{p + 1 + k, 1'b0, d};
    end
    expq.push_back(e);
    @(posedge clk); #1;
    noise_excl(0);
    @(posedge clk); #1;
    req = 1'b0;
    exp_busy = 1'b0;
  endtask

  // Reset in the middle of WAIT must drop the transaction silently.
  task automatic reset_mid();
    req = 1'b1;
    select = SW'(2);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    repeat (2) begin
      drive_wait(2, 1'b0);
      @(posedge clk); #1;
    end
    drive_wait(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 1'b0;
    s_ready = '0;
    exp_busy = 1'b0;
    model_rdata = '0;
    idle(3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;
    idle(2);
    issue(2, 3, 8'hA5, 1'b0);
    idle(1);
    issue(2, 4, 8'h11, 1'b1);
    issue(0, 1, 8'h00, 1'b0);
    issue(6, 1, 8'h00, 1'b0);
    issue(7, 1, 8'h00, 1'b0);
    issue(5, 1, 8'hC3, 1'b0);
    issue(1, 16, 8'h5A, 1'b0);
    if (TO_EN) issue(1, 100, 8'h00, 1'b0);
    else issue(1, 101, 8'h7E, 1'b0);
    idle(2);
    reset_mid();
    repeat (60) begin
      idle(int'($urandom_range(0, 3)));
      issue(int'($urandom_range(0, 7)), int'($urandom_range(1, TO_EN ? 20 : 12)),
            DW'($urandom()), 1'b0);
    end
    idle(5);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
